// File: rtl/uart_pkg.sv
// Shared UART receive-path constants and the capture FSM state type.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_RXF_DEPTH = 16;

    typedef enum logic {
        CAP_IDLE,
        CAP_ARMED
    } cap_state_t;

endpackage

// File: rtl/uart_rx_capture.sv
// Turns the receiver's multi-cycle done level into a single push request per frame,
// carrying the byte sampled one cycle after the rising edge of done.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              push_req,
    output logic [DATA_W-1:0] push_data
);

    cap_state_t state, state_nxt;
    logic       done_d;

    // done_d resets high so a done level already asserted at reset release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= CAP_IDLE;
            done_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            done_d <= i_rx_done;
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_data = '0;
        case (state)
            CAP_IDLE: begin
                if (i_rx_done && !done_d) state_nxt = CAP_ARMED;
            end
            CAP_ARMED: begin
                push_req  = 1'b1;
                push_data = i_rx_data;
                state_nxt = CAP_IDLE;
            end
            default: state_nxt = CAP_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one push per received frame into a FWFT FIFO with level, full/empty
// and sticky overflow. Optional threshold interrupt when UART_RX_FIFO_IRQ_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_RXF_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rd_en,
    input  logic              i_clr_ovf,
`ifdef UART_RX_FIFO_IRQ_EN
    input  logic [ADDR_W:0]   i_thresh,
    output logic              o_irq,
`endif
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic              push_req;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              pop, wr_en, ovf_set, ovf_nxt;

    uart_rx_capture #(
        .DATA_W (DATA_W)
    ) u_capture (
        .clk       (clk),
        .reset     (reset),
        .i_rx_done (i_rx_done),
        .i_rx_data (i_rx_data),
        .push_req  (push_req),
        .push_data (push_data)
    );

    // A pop frees the slot the push needs, so full + push + pop is legal and does not overflow
    assign pop     = i_rd_en & ~o_empty;
    assign wr_en   = push_req & (~o_full | pop);
    assign ovf_set = push_req & o_full & ~pop;

    assign wr_ptr_nxt = wr_en ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_nxt = pop   ? rd_ptr + 1'b1 : rd_ptr;
    assign ovf_nxt    = ovf_set | (o_overflow & ~i_clr_ovf);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            o_overflow <= ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

    assign o_level   = wr_ptr - rd_ptr;
    assign o_empty   = (o_level == '0);
    assign o_full    = (o_level == DEPTH_L);
    assign o_rd_data = o_empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

`ifdef UART_RX_FIFO_IRQ_EN
    logic [ADDR_W:0] level_nxt;
    logic            irq_nxt;

    // Evaluated on next-cycle state so the interrupt moves in step with o_level/o_overflow
    assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    assign irq_nxt   = ((i_thresh != '0) && (level_nxt >= i_thresh)) || ovf_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_irq <= 1'b0;
        else        o_irq <= irq_nxt;
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; IRQ checks run when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic       i_rd_en;
    logic       i_clr_ovf;
    logic [7:0] o_rd_data;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_level;
    logic       o_overflow;
`ifdef UART_RX_FIFO_IRQ_EN
    logic [4:0] i_thresh;
    logic       o_irq;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_done  (i_rx_done),
        .i_rx_data  (i_rx_data),
        .i_rd_en    (i_rd_en),
        .i_clr_ovf  (i_clr_ovf),
`ifdef UART_RX_FIFO_IRQ_EN
        .i_thresh   (i_thresh),
        .o_irq      (o_irq),
`endif
        .o_rd_data  (o_rd_data),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One receiver frame: done rises, byte appears on the 2nd cycle, done held for 'hold' cycles
    task automatic frame(input logic [7:0] b, input int hold, input logic pop_at_push);
        i_rx_done = 1'b1;
        i_rx_data = 8'h00;
        tick();
        i_rx_data = b;
        i_rd_en   = pop_at_push;
        tick();
        i_rd_en   = 1'b0;
        for (int k = 2; k < hold; k++) tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        tick();
    endtask

    task automatic pop_one();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(o_level), 32'd0);
        chk({tag, "_empty"}, 32'(o_empty), 32'd1);
        chk({tag, "_full"},  32'(o_full),  32'd0);
        chk({tag, "_ovf"},   32'(o_overflow), 32'd0);
        chk({tag, "_rdata"}, 32'(o_rd_data), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_rd_en   = 1'b0;
        i_clr_ovf = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
        i_thresh  = 5'd0;
`endif
        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (2) tick();

        // 1: long done level, single push visible two cycles after the edge
        i_rx_done = 1'b1;
        tick();
        i_rx_data = 8'hA5;
        tick();
        chk("t1_level_2cyc", 32'(o_level), 32'd1);
        chk("t1_rdata_2cyc", 32'(o_rd_data), 32'hA5);
        chk("t1_empty_2cyc", 32'(o_empty), 32'd0);
        repeat (14) tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        repeat (2) tick();
        chk("t1_level_once", 32'(o_level), 32'd1);
        pop_one();
        chk("t1_empty_after_pop", 32'(o_empty), 32'd1);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < 16; i++) frame(8'(i), 3, 1'b0);
        chk("t2_full", 32'(o_full), 32'd1);
        chk("t2_level16", 32'(o_level), 32'd16);
        chk("t2_ovf_pre", 32'(o_overflow), 32'd0);
        frame(8'hFF, 3, 1'b0);
        chk("t2_ovf", 32'(o_overflow), 32'd1);
        chk("t2_level_ovf", 32'(o_level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_rd%0d", i), 32'(o_rd_data), 32'(i));
            pop_one();
        end
        chk("t2_empty", 32'(o_empty), 32'd1);
        chk("t2_rdata_empty", 32'(o_rd_data), 32'd0);
        chk("t2_ovf_sticky", 32'(o_overflow), 32'd1);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        chk("t2_ovf_clr", 32'(o_overflow), 32'd0);

        // 3: push coinciding with pop on a full FIFO
        for (int i = 0; i < 16; i++) frame(8'(8'h10 + i), 3, 1'b0);
        frame(8'hC3, 3, 1'b1);
        chk("t3_level", 32'(o_level), 32'd16);
        chk("t3_ovf", 32'(o_overflow), 32'd0);
        chk("t3_full", 32'(o_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_rd%0d", i), 32'(o_rd_data), (i == 15) ? 32'hC3 : 32'(8'h11 + i));
            pop_one();
        end
        chk("t3_empty", 32'(o_empty), 32'd1);

        // 4: pops on an empty FIFO are ignored
        i_rd_en = 1'b1;
        repeat (3) tick();
        i_rd_en = 1'b0;
        chk("t4_level", 32'(o_level), 32'd0);
        chk("t4_empty", 32'(o_empty), 32'd1);
        chk("t4_rdata", 32'(o_rd_data), 32'd0);
        frame(8'h5A, 3, 1'b0);
        chk("t4_level_push", 32'(o_level), 32'd1);
        chk("t4_rdata_push", 32'(o_rd_data), 32'h5A);
        pop_one();

        // 5: reset while ARMED with 3 bytes stored, done still high after release
        for (int i = 0; i < 3; i++) frame(8'(8'h30 + i), 3, 1'b0);
        chk("t5_level3", 32'(o_level), 32'd3);
        i_rx_done = 1'b1;
        i_rx_data = 8'h77;
        tick();
        reset = 1'b0;
        #1;
        check_reset_vals("t5");
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("t5_no_push_level", 32'(o_level), 32'd0);
        chk("t5_no_push_empty", 32'(o_empty), 32'd1);
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        repeat (2) tick();
        chk("t5_still_empty", 32'(o_level), 32'd0);

`ifdef UART_RX_FIFO_IRQ_EN
        // 6: threshold interrupt
        i_thresh = 5'd4;
        for (int i = 0; i < 3; i++) frame(8'(8'h40 + i), 3, 1'b0);
        chk("t6_irq_3", 32'(o_irq), 32'd0);
        frame(8'h43, 3, 1'b0);
        chk("t6_irq_4", 32'(o_irq), 32'd1);
        pop_one();
        tick();
        chk("t6_irq_pop", 32'(o_irq), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
